// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG sequencing logic.
package prng_pkg;

    localparam int                    PRNG_WIDTH    = 8;
    localparam int                    IDX_W         = 3;
    localparam logic [PRNG_WIDTH-1:0] PRNG_DEF_SEED = 8'hA5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RESEED = 3'd1,
        WARM   = 3'd2,
        STEP   = 3'd3,
        SERVE  = 3'd4,
        CHECK  = 3'd5
    } state_e;

    // Advance a round-robin index by one, wrapping from n-1 back to 0.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return {IDX_W{1'b0}};
        end else begin
            return idx + IDX_W'(1);
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i.
module rr_pick
    import prng_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     oh_o,
    output logic [IDX_W-1:0] idx_o
);

    logic found_s;
    int   j_s;

    // Scan N positions starting at the pointer and latch the first hit.
    always_comb begin
        oh_o    = {N{1'b0}};
        idx_o   = {IDX_W{1'b0}};
        found_s = 1'b0;
        j_s     = 0;
        for (int i = 0; i < N; i++) begin
            j_s = int'(ptr_i) + i;
            if (j_s >= N) begin
                j_s = j_s - N;
            end else begin
                j_s = j_s;
            end
            if (!found_s && req_i[j_s]) begin
                found_s   = 1'b1;
                oh_o[j_s] = 1'b1;
                idx_o     = IDX_W'(j_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/prng8_arbiter.sv
// Round-robin scheduler sharing one 8-bit LFSR between requesters; owns
// reseed, warm-up, per-request stepping and stuck-at-zero recovery.
module prng8_arbiter
    import prng_pkg::*;
#(
    parameter int                NREQ     = 4,
    parameter int                WIDTH    = PRNG_WIDTH,
    parameter int                WARMUP   = 4,
    parameter logic [WIDTH-1:0]  DEF_SEED = PRNG_DEF_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       rsp_id,
    input  logic             seed_req,
    input  logic [WIDTH-1:0] seed_val,
    output logic             seed_ack,
    output logic             busy,
    output logic             prng_update,
    output logic             prng_reseed,
    output logic [WIDTH-1:0] prng_seed,
    input  logic [WIDTH-1:0] prng_rand
);

    state_e             state_q, state_d;
    // live_q holds every output at zero for the first cycle after reset so
    // the RESEED reset state never drives the PRNG while rst is high.
    logic               live_q;
    logic [WIDTH-1:0]   pend_q, pend_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;

    logic [NREQ-1:0]    pick_oh_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [NREQ-1:0]    sel_oh_s;
    logic               sel_live_s;

    rr_pick #(.N(NREQ)) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .oh_o  (pick_oh_s),
        .idx_o (pick_idx_s)
    );

    assign sel_oh_s   = {{(NREQ-1){1'b0}}, 1'b1} << sel_q;
    // A requester that dropped its request before the grant is skipped.
    assign sel_live_s = |(req & sel_oh_s);

    // Next-state and output decode; every output defaults to zero.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        gnt         = {NREQ{1'b0}};
        rsp_valid   = 1'b0;
        rsp_data    = {WIDTH{1'b0}};
        rsp_id      = 3'd0;
        seed_ack    = 1'b0;
        busy        = 1'b0;
        prng_update = 1'b0;
        prng_reseed = 1'b0;
        prng_seed   = {WIDTH{1'b0}};
        if (!live_q) begin
            state_d = RESEED;
            pend_d  = DEF_SEED;
        end else begin
            busy = (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (seed_req) begin
                        seed_ack = 1'b1;
                        pend_d   = (seed_val == {WIDTH{1'b0}}) ? DEF_SEED : seed_val;
                        state_d  = RESEED;
                    end else if (|pick_oh_s) begin
                        sel_d   = pick_idx_s;
                        state_d = STEP;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RESEED: begin
                    prng_reseed = 1'b1;
                    prng_seed   = pend_q;
                    cnt_d       = 4'd0;
                    state_d     = WARM;
                end
                WARM: begin
                    prng_update = 1'b1;
                    cnt_d       = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                    if (cnt_q >= 4'(WARMUP - 1)) begin
                        state_d = CHECK;
                    end else begin
                        state_d = WARM;
                    end
                end
                STEP: begin
                    if (sel_live_s) begin
                        prng_update = 1'b1;
                        gnt         = sel_oh_s;
                        ptr_d       = rr_next(sel_q, NREQ);
                        state_d     = SERVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SERVE: begin
                    rsp_valid = 1'b1;
                    rsp_data  = prng_rand;
                    rsp_id    = sel_q;
                    if (prng_rand == {WIDTH{1'b0}}) begin
                        pend_d  = DEF_SEED;
                        state_d = RESEED;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CHECK: begin
                    if (prng_rand == {WIDTH{1'b0}}) begin
                        pend_d  = DEF_SEED;
                        state_d = RESEED;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    pend_d  = DEF_SEED;
                    state_d = RESEED;
                end
            endcase
        end
    end

    // State, pointer, pending seed and warm-up counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESEED;
            live_q  <= 1'b0;
            pend_q  <= DEF_SEED;
            cnt_q   <= 4'd0;
            ptr_q   <= {IDX_W{1'b0}};
            sel_q   <= {IDX_W{1'b0}};
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

endmodule
